// File: rtl/simple_mem_loader.sv
// Word-addressed program/data RAM for simple_proc, with a boot loader that streams a program in while the core is held in reset.
// Optional MEM_STATS_EN adds saturating read/write counters for the RUN phase.
module simple_mem_loader #(
  parameter int width    = 32,
  parameter int addrsize = 8,
  parameter int memsize  = 1 << addrsize,
  parameter int cntw     = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                we,
  input  logic [addrsize-1:0] address,
  input  logic [width-1:0]    datain,
  output logic [width-1:0]    dataout,
  input  logic                ld_valid,
  input  logic [width-1:0]    ld_data,
  input  logic                ld_last,
  output logic                ld_ready,
  output logic                core_nrst,
  output logic                ld_done
`ifdef MEM_STATS_EN
  ,
  output logic [cntw-1:0]     rd_count,
  output logic [cntw-1:0]     wr_count
`endif
);

  typedef enum logic {LOAD, RUN} state_t;

  localparam logic [addrsize-1:0] PTR_MAX = addrsize'(memsize - 1);

  logic [width-1:0] mem [memsize];

  state_t              state_q, state_d;
  logic [addrsize-1:0] ptr_q, ptr_d;
  logic                ld_ready_q, ld_ready_d;
  logic                core_nrst_q, core_nrst_d;
  logic                ld_done_q, ld_done_d;
  logic [width-1:0]    dataout_q;

  logic                wr_en, rd_en;
  logic [addrsize-1:0] wr_addr;
  logic [width-1:0]    wr_data;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ld_done_d = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    wr_addr   = ptr_q;
    wr_data   = ld_data;
    case (state_q)
      LOAD: begin
        if (ld_valid) begin
          wr_en = 1'b1;
          if (ld_last || ptr_q == PTR_MAX) begin
            state_d   = RUN;
            ld_done_d = 1'b1;
          end
          // Hold at the top word so the pointer can never wrap.
          if (ptr_q != PTR_MAX) ptr_d = ptr_q + 1'b1;
        end
      end
      RUN: begin
        if (we) begin
          wr_en   = 1'b1;
          wr_addr = address;
          wr_data = datain;
        end else begin
          rd_en = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
    // No RAM traffic while the block itself is being reset.
    if (!nrst) begin
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
    ld_ready_d  = (state_d == LOAD);
    core_nrst_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= LOAD;
      ptr_q       <= '0;
      ld_ready_q  <= 1'b1;
      core_nrst_q <= 1'b0;
      ld_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ld_ready_q  <= ld_ready_d;
      core_nrst_q <= core_nrst_d;
      ld_done_q   <= ld_done_d;
    end
  end

  // RAM array kept free of reset so it maps onto block RAM and retains contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!nrst) dataout_q <= '0;
    else if (rd_en) dataout_q <= mem[address];
  end

  assign dataout   = dataout_q;
  assign ld_ready  = ld_ready_q;
  assign core_nrst = core_nrst_q;
  assign ld_done   = ld_done_q;

`ifdef MEM_STATS_EN
  logic [cntw-1:0] rd_count_q, rd_count_d;
  logic [cntw-1:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (rd_en && rd_count_q != '1) rd_count_d = rd_count_q + 1'b1;
    if (state_q == RUN && wr_en && wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_simple_mem_loader.sv
// Directed bench for simple_mem_loader: boot loading, RUN reads/writes, full-memory stream and mid-RUN reset.
// Define MEM_STATS_EN to also check the read/write counters.
module tb_simple_mem_loader;

  logic        clk = 1'b0;
  logic        nrst, we, ld_valid, ld_last;
  logic [7:0]  address;
  logic [31:0] datain, ld_data;
  logic [31:0] dataout;
  logic        ld_ready, core_nrst, ld_done;
`ifdef MEM_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  simple_mem_loader dut (
    .clk(clk), .nrst(nrst), .we(we), .address(address), .datain(datain),
    .dataout(dataout), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .core_nrst(core_nrst), .ld_done(ld_done)
`ifdef MEM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {8'hA5, b, ~b, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    we       = 1'b1;
    address  = 8'd5;
    datain   = 32'hBADBAD00;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a);
    we      = 1'b0;
    address = a;
    tick();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    we      = 1'b1;
    address = a;
    datain  = d;
    tick();
    we      = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; we = 1'b1; address = '0; datain = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    tests++;
    if ({dataout, core_nrst, ld_ready, ld_done} !== {32'h0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: dataout=%h core_nrst=%b ld_ready=%b ld_done=%b, want 0/0/1/0",
               dataout, core_nrst, ld_ready, ld_done);
    end
    tick(); tick();
    tests++;
    if ({core_nrst, ld_ready, ld_done} !== 3'b010) begin
      fails++;
      $display("FAIL idle_load: core_nrst=%b ld_ready=%b ld_done=%b, want 0/1/0", core_nrst, ld_ready, ld_done);
    end
`ifdef MEM_STATS_EN
    tests++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_stats: rd=%0d wr=%0d, want 0/0", rd_count, wr_count);
    end
`endif
  endtask

  task automatic test_full_stream();
    int early_run = 0;
    for (int i = 0; i < 256; i++) begin
      load_word(pat(i), 1'b0);
      if (i < 255 && (ld_ready !== 1'b1 || core_nrst !== 1'b0 || ld_done !== 1'b0)) early_run++;
    end
    tests++;
    if (early_run != 0) begin
      fails++;
      $display("FAIL stream_stays_load: left LOAD early on %0d words, want 0", early_run);
    end
    tests++;
    if ({ld_ready, core_nrst, ld_done} !== 3'b011) begin
      fails++;
      $display("FAIL stream_end: ld_ready=%b core_nrst=%b ld_done=%b, want 0/1/1", ld_ready, core_nrst, ld_done);
    end
    // A 257th word is offered while the core reads address 0.
    we = 1'b0; address = 8'd0;
    ld_valid = 1'b1; ld_data = 32'hBAD0BAD0; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    tests++;
    if (dataout !== pat(0) || ld_done !== 1'b0) begin
      fails++;
      $display("FAIL stream_word0: dataout=%h ld_done=%b, want %h/0", dataout, ld_done, pat(0));
    end
    do_read(8'd255);
    tests++;
    if (dataout !== pat(255)) begin
      fails++;
      $display("FAIL stream_word255: dataout=%h, want %h", dataout, pat(255));
    end
    do_read(8'd127);
    tests++;
    if (dataout !== pat(127)) begin
      fails++;
      $display("FAIL stream_word127: dataout=%h, want %h", dataout, pat(127));
    end
    $display("[TB] full stream: 256 words loaded, extra word offered");
  endtask

  task automatic test_gap_load();
    logic [31:0] words [3];
    int gap_bad = 0;
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    pulse_reset();
    for (int w = 0; w < 3; w++) begin
      load_word(words[w], w == 2);
      if (w < 2) begin
        for (int g = 0; g < 2; g++) begin
          ld_data = 32'hFFFF0000;
          tick();
          if (ld_ready !== 1'b1 || core_nrst !== 1'b0 || ld_done !== 1'b0) gap_bad++;
        end
      end
    end
    tests++;
    if (gap_bad != 0) begin
      fails++;
      $display("FAIL gap_state: %0d bad gap cycles, want 0", gap_bad);
    end
    tests++;
    if ({ld_ready, core_nrst, ld_done} !== 3'b011) begin
      fails++;
      $display("FAIL gap_end: ld_ready=%b core_nrst=%b ld_done=%b, want 0/1/1", ld_ready, core_nrst, ld_done);
    end
    for (int a = 0; a < 4; a++) begin
      do_read(8'(a));
      tests++;
      if (dataout !== ((a < 3) ? words[a] : pat(3))) begin
        fails++;
        $display("FAIL gap_mem%0d: dataout=%h, want %h", a, dataout, (a < 3) ? words[a] : pat(3));
      end
    end
    $display("[TB] gap load: 3 words with 2-cycle gaps");
  endtask

  task automatic test_load3();
    pulse_reset();
    tests++;
    if (core_nrst !== 1'b0 || ld_ready !== 1'b1) begin
      fails++;
      $display("FAIL load3_reset: core_nrst=%b ld_ready=%b, want 0/1", core_nrst, ld_ready);
    end
    load_word(32'h11, 1'b0);
    load_word(32'h22, 1'b0);
    load_word(32'h33, 1'b1);
    tests++;
    if ({ld_ready, core_nrst, ld_done} !== 3'b011) begin
      fails++;
      $display("FAIL load3_end: ld_ready=%b core_nrst=%b ld_done=%b, want 0/1/1", ld_ready, core_nrst, ld_done);
    end
    do_read(8'd0);
    tests++;
    if (dataout !== 32'h11 || ld_done !== 1'b0) begin
      fails++;
      $display("FAIL load3_mem0: dataout=%h ld_done=%b, want 00000011/0", dataout, ld_done);
    end
    do_read(8'd2);
    tests++;
    if (dataout !== 32'h33) begin
      fails++;
      $display("FAIL load3_mem2: dataout=%h, want 00000033", dataout);
    end
    $display("[TB] load3: 0x11,0x22,0x33 loaded");
  endtask

  task automatic test_read_hold();
    do_read(8'd1);
    tests++;
    if (dataout !== 32'h22) begin
      fails++;
      $display("FAIL read1: dataout=%h, want 00000022", dataout);
    end
    do_write(8'd7, 32'h77);
    tests++;
    if (dataout !== 32'h22) begin
      fails++;
      $display("FAIL read_hold: dataout=%h, want 00000022", dataout);
    end
    $display("[TB] read/hold: addr 1");
  endtask

  task automatic test_write_read();
    do_write(8'd5, 32'hDEADBEEF);
    do_read(8'd5);
    tests++;
    if (dataout !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL write_read5: dataout=%h, want deadbeef", dataout);
    end
    do_read(8'd7);
    tests++;
    if (dataout !== 32'h77) begin
      fails++;
      $display("FAIL write_read7: dataout=%h, want 00000077", dataout);
    end
    $display("[TB] write/read: addr 5 and 7");
  endtask

  task automatic test_run_reset();
    we = 1'b0; address = 8'd1;
    nrst = 1'b0;
    tick();
    tests++;
    if ({core_nrst, ld_ready, ld_done, dataout} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL run_reset: core_nrst=%b ld_ready=%b ld_done=%b dataout=%h, want 0/1/0/0",
               core_nrst, ld_ready, ld_done, dataout);
    end
`ifdef MEM_STATS_EN
    tests++;
    if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
      fails++;
      $display("FAIL run_reset_stats: rd=%0d wr=%0d, want 0/0", rd_count, wr_count);
    end
`endif
    nrst = 1'b1;
    load_word(32'h99, 1'b1);
    do_read(8'd0);
    tests++;
    if (dataout !== 32'h99) begin
      fails++;
      $display("FAIL reload_mem0: dataout=%h, want 00000099", dataout);
    end
    do_read(8'd1);
    tests++;
    if (dataout !== 32'h22) begin
      fails++;
      $display("FAIL reload_mem1: dataout=%h, want 00000022", dataout);
    end
    do_read(8'd5);
    tests++;
    if (dataout !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL reload_mem5: dataout=%h, want deadbeef", dataout);
    end
    do_write(8'd9, 32'h1234);
`ifdef MEM_STATS_EN
    tests++;
    if (rd_count !== 16'd3 || wr_count !== 16'd1) begin
      fails++;
      $display("FAIL stats_count: rd=%0d wr=%0d, want 3/1", rd_count, wr_count);
    end
`endif
    $display("[TB] run reset: reload of 1 word, RAM retained");
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_gap_load();
    test_load3();
    test_read_hold();
    test_write_read();
    test_run_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
